// File: rtl/instr_mem_ld_if.sv
// instr_mem_ld_if: fetch and load ports of instr_mem_ld.
// With IM_PARITY_EN defined it also carries ld_par_inj and par_err.
interface instr_mem_ld_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              im_cs;
  logic [ADDR_W-1:0] address;
  logic              fetch_req;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              busy;
  logic              loaded;
`ifdef IM_PARITY_EN
  logic              ld_par_inj;
  logic              par_err;
  modport master (
    output im_cs, address, fetch_req, ld_start, ld_valid, ld_data, ld_par_inj,
    input  data, data_valid, ld_ready, ld_done, busy, loaded, par_err
  );
  modport slave (
    input  im_cs, address, fetch_req, ld_start, ld_valid, ld_data, ld_par_inj,
    output data, data_valid, ld_ready, ld_done, busy, loaded, par_err
  );
`else
  modport master (
    output im_cs, address, fetch_req, ld_start, ld_valid, ld_data,
    input  data, data_valid, ld_ready, ld_done, busy, loaded
  );
  modport slave (
    input  im_cs, address, fetch_req, ld_start, ld_valid, ld_data,
    output data, data_valid, ld_ready, ld_done, busy, loaded
  );
`endif
endinterface

// File: rtl/instr_mem_ld.sv
// instr_mem_ld: loadable DEPTH x DATA_W instruction RAM with streaming load FSM and registered fetch.
// Optional macro IM_PARITY_EN adds a stored even-parity bit per word, ld_par_inj and par_err.
module instr_mem_ld #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic           clk,
  input logic           rst_n,
  instr_mem_ld_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
`ifdef IM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_ld_addr;
  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0] r_data;
  logic              r_data_valid;
  logic              r_ld_ready;
  logic              r_ld_done;
  logic              r_busy;
  logic              r_loaded;
  logic              w_serve;
  logic              w_wr;
  logic [MEM_W-1:0]  w_wr_word;
  logic [MEM_W-1:0]  w_rd_word;
  // Fetches are served only from a completely loaded RAM while no load is in flight
  assign w_serve   = bus.im_cs && r_loaded && r_state == IDLE;
  assign w_wr      = r_state == LOAD && bus.ld_valid;
  assign w_rd_word = r_mem[bus.address];
`ifdef IM_PARITY_EN
  logic r_par_err;
  assign w_wr_word   = {(^bus.ld_data) ^ bus.ld_par_inj, bus.ld_data};
  assign bus.par_err = r_par_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_par_err <= 1'b0;
    else        r_par_err <= bus.fetch_req && w_serve && (^w_rd_word);
`else
  assign w_wr_word = bus.ld_data;
`endif
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_ld_addr] <= w_wr_word;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ld_addr    <= '0;
      r_data       <= NOP_WORD;
      r_data_valid <= 1'b0;
      r_ld_ready   <= 1'b0;
      r_ld_done    <= 1'b0;
      r_busy       <= 1'b0;
      r_loaded     <= 1'b0;
    end else begin
      r_data_valid <= bus.fetch_req;
      if (bus.fetch_req) r_data <= w_serve ? w_rd_word[DATA_W-1:0] : NOP_WORD;
      r_ld_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.ld_start) begin
          r_state    <= LOAD;
          r_ld_addr  <= '0;
          r_loaded   <= 1'b0;
          r_ld_ready <= 1'b1;
          r_busy     <= 1'b1;
        end
        LOAD: if (bus.ld_valid) begin
          r_ld_addr <= r_ld_addr + 1'b1;
          if (&r_ld_addr) begin
            r_state    <= DONE;
            r_ld_ready <= 1'b0;
            r_ld_done  <= 1'b1;
            r_loaded   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  assign bus.data       = r_data;
  assign bus.data_valid = r_data_valid;
  assign bus.ld_ready   = r_ld_ready;
  assign bus.ld_done    = r_ld_done;
  assign bus.busy       = r_busy;
  assign bus.loaded     = r_loaded;
endmodule

// File: tb/tb_instr_mem_ld.sv
// tb_instr_mem_ld: directed stimulus for instr_mem_ld, checked every cycle against a phase/count model
// plus literal expectations; parity cases run when IM_PARITY_EN is defined.
module tb_instr_mem_ld;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_mem_ld_if #(.DATA_W(8), .ADDR_W(2)) bus ();
  instr_mem_ld #(.DATA_W(8), .ADDR_W(2), .NOP_WORD(8'h00)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: phase 0 idle, 1 loading, 2 done; m_cnt counts words accepted in the current load
  logic [7:0] m_mem [4];
  bit         m_par_ok [4];
  int         m_phase = 0;
  int         m_cnt = 0;
  bit         m_loaded = 0;
  logic [7:0] e_data = 8'h00;
  bit         e_valid = 0;
  bit         e_par = 0;
  bit         srv;
  bit         inj_now;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_data = 8'h00; e_valid = 0; e_par = 0;
      m_phase = 0; m_cnt = 0; m_loaded = 0;
    end else begin
`ifdef IM_PARITY_EN
      inj_now = bus.ld_par_inj;
`else
      inj_now = 0;
`endif
      srv = bus.im_cs && m_loaded && m_phase == 0;
      e_valid = bus.fetch_req;
      e_par = 0;
      if (bus.fetch_req) begin
        e_data = srv ? m_mem[bus.address] : 8'h00;
        e_par = srv && !m_par_ok[bus.address];
      end
      if (m_phase == 2) m_phase = 0;
      else if (m_phase == 1) begin
        if (bus.ld_valid) begin
          m_mem[m_cnt] = bus.ld_data;
          m_par_ok[m_cnt] = !inj_now;
          m_cnt++;
          if (m_cnt == 4) begin m_phase = 2; m_loaded = 1; end
        end
      end else if (bus.ld_start) begin
        m_phase = 1; m_cnt = 0; m_loaded = 0;
      end
    end
  end
  always @(negedge clk)
    if (rst_n) begin
      chk("data", bus.data, e_data);
      chk("data_valid", bus.data_valid, e_valid);
      chk("ld_ready", bus.ld_ready, 32'(m_phase == 1));
      chk("ld_done", bus.ld_done, 32'(m_phase == 2));
      chk("busy", bus.busy, 32'(m_phase != 0));
      chk("loaded", bus.loaded, 32'(m_loaded));
`ifdef IM_PARITY_EN
      chk("par_err", bus.par_err, 32'(e_par));
`endif
    end
  // words packed as {w3,w2,w1,w0}; vpat bit i is ld_valid in load cycle i
  task automatic load(input logic [31:0] words, input logic [15:0] vpat, input int n,
                      input bit hold_start, input bit fetch, input logic [3:0] inj);
    int w;
    w = 0;
    @(negedge clk);
    bus.ld_start = 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (fetch && i > 0) begin
        chk("reload_fetch_nop", bus.data, 8'h00);
        chk("reload_loaded_low", bus.loaded, 0);
      end
      bus.ld_start = hold_start;
      bus.ld_valid = vpat[i];
      bus.ld_data = vpat[i] ? words[8*w +: 8] : 8'hFF;
`ifdef IM_PARITY_EN
      bus.ld_par_inj = vpat[i] && inj[w];
`endif
      bus.fetch_req = fetch;
      bus.im_cs = fetch;
      bus.address = 2'(i);
      if (vpat[i]) w++;
    end
    @(negedge clk);
    bus.ld_start = 0; bus.ld_valid = 0; bus.fetch_req = 0;
`ifdef IM_PARITY_EN
    bus.ld_par_inj = 0;
`endif
    chk("ld_done_pulse", bus.ld_done, 1);
    chk("loaded_set", bus.loaded, 1);
    chk("ld_ready_off", bus.ld_ready, 0);
    @(negedge clk);
    chk("busy_off", bus.busy, 0);
    chk("ld_done_single", bus.ld_done, 0);
  endtask
  task automatic readback(input logic [31:0] words);
    for (int a = 0; a < 5; a++) begin
      @(negedge clk);
      if (a > 0) begin
        chk("rb_data", bus.data, words[8*(a-1) +: 8]);
        chk("rb_valid", bus.data_valid, 1);
      end
      bus.fetch_req = a < 4;
      bus.im_cs = 1;
      bus.address = 2'(a);
    end
  endtask
  initial begin
    bus.im_cs = 0; bus.address = 0; bus.fetch_req = 0;
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_data = 0;
`ifdef IM_PARITY_EN
    bus.ld_par_inj = 0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data, 8'h00);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_loaded", bus.loaded, 0);
    rst_n = 1;
    // 1: fetch before any load returns NOP
    @(negedge clk);
    bus.fetch_req = 1; bus.im_cs = 1; bus.address = 2'd1;
    @(negedge clk);
    bus.fetch_req = 0;
    chk("t1_data", bus.data, 8'h00);
    chk("t1_valid", bus.data_valid, 1);
    chk("t1_loaded", bus.loaded, 0);
    // 2: continuous load and back-to-back readback
    load(32'hB0608424, 16'h000F, 4, 0, 0, 4'b0000);
    readback(32'hB0608424);
    // 3: gapped load, ld_start held high throughout
    load(32'h44332211, 16'h0059, 7, 1, 0, 4'b0000);
    readback(32'h44332211);
    // 4: chip select low, then fetches during a reload
    @(negedge clk);
    bus.fetch_req = 1; bus.im_cs = 0; bus.address = 2'd2;
    @(negedge clk);
    bus.fetch_req = 0;
    chk("t4_cs_low_data", bus.data, 8'h00);
    chk("t4_cs_low_valid", bus.data_valid, 1);
    load(32'h87654321, 16'h000F, 4, 0, 1, 4'b0000);
    readback(32'h87654321);
    // 5: reset after two of four load words
    @(negedge clk);
    bus.ld_start = 1;
    @(negedge clk);
    bus.ld_start = 0; bus.ld_valid = 1; bus.ld_data = 8'hC1;
    @(negedge clk);
    bus.ld_data = 8'hC2;
    @(negedge clk);
    bus.ld_valid = 0;
    rst_n = 0;
    #1;
    chk("t5_rst_data", bus.data, 8'h00);
    chk("t5_rst_valid", bus.data_valid, 0);
    chk("t5_rst_ready", bus.ld_ready, 0);
    chk("t5_rst_done", bus.ld_done, 0);
    chk("t5_rst_busy", bus.busy, 0);
    chk("t5_rst_loaded", bus.loaded, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    bus.fetch_req = 1; bus.im_cs = 1; bus.address = 2'd0;
    @(negedge clk);
    bus.fetch_req = 0;
    chk("t5_fetch_nop", bus.data, 8'h00);
    load(32'h5A3C0FF1, 16'h000F, 4, 0, 0, 4'b0000);
    readback(32'h5A3C0FF1);
`ifdef IM_PARITY_EN
    // 6: parity error injected on word 3 only
    load(32'hB0608424, 16'h000F, 4, 0, 0, 4'b1000);
    for (int a = 0; a < 5; a++) begin
      @(negedge clk);
      if (a > 0) begin
        chk("t6_data", bus.data, 32'hB0608424 >> (8*(a-1)) & 32'hFF);
        chk("t6_par_err", bus.par_err, 32'(a == 4));
      end
      bus.fetch_req = a < 4; bus.im_cs = 1; bus.address = 2'(a);
    end
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/instr_mem_ld.md
Name: instr_mem_ld

Overview:
Parametrised, loadable instruction memory for the RISC core fetch stage. It replaces fixed hard-coded program words with a DEPTH x DATA_W RAM. The RAM is filled through a streaming load port driven by a small FSM, and is read through a registered fetch port with chip-select. The fetch unit drives address/im_cs/fetch_req; a host or boot block drives the ld_* port.

Parameters:
DATA_W, 8, instruction word width in bits
ADDR_W, 2, address width; DEPTH = 2**ADDR_W words
NOP_WORD, 0, value returned on a fetch that is not served from the RAM (DATA_W bits)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
im_cs  in  1  chip select for fetch
address  in  ADDR_W  fetch address
fetch_req  in  1  fetch strobe, sampled on clk
data  out  DATA_W  fetched instruction, registered
data_valid  out  1  one-cycle pulse, data updated this cycle
ld_start  in  1  begin full-program load, sampled in IDLE only
ld_valid  in  1  ld_data valid
ld_data  in  DATA_W  program word
ld_ready  out  1  high in LOAD state
ld_done  out  1  one-cycle pulse after last word is written
busy  out  1  high whenever the FSM is not IDLE
loaded  out  1  a complete program is resident

Behaviour:
- Reset (async assert, sync release): data=NOP_WORD, data_valid=0, ld_ready=0, ld_done=0, busy=0, loaded=0, state=IDLE, ld_addr=0. RAM contents are not cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on ld_start=1. Entering LOAD sets ld_addr=0 and clears loaded the same edge.
- LOAD: ld_ready=1. Each cycle with ld_valid=1 writes mem[ld_addr]=ld_data and increments ld_addr. ld_valid=0 stalls with no write and no increment. ld_start is ignored in LOAD.
- The write at ld_addr=DEPTH-1 moves the FSM to DONE; ld_addr wraps to 0.
- DONE (exactly 1 cycle): ld_done=1, ld_ready=0, and loaded is set. The FSM then returns to IDLE.
- ld_start in IDLE while loaded=1 starts a reload.
- Fetch latency is 1 cycle. If fetch_req=1 at edge N, then at edge N+1 data_valid=1 for one cycle and data is loaded:
  - mem[address] if im_cs=1 and loaded=1 and state==IDLE;
  - otherwise NOP_WORD.
- Without fetch_req, data holds its last value and data_valid=0.
- A fetch and a load write never target the RAM in the same cycle, because fetches during busy return NOP_WORD. No read/write collision rule is needed.
- Back-to-back fetch_req every cycle is sustained at 1 word/cycle.
- Reset mid-load aborts the load: state=IDLE, loaded=0. Partially written words remain in the RAM but are not fetchable until a full load completes.
- address is taken modulo DEPTH (full width, no out-of-range case).

Optional Feature:
Macro IM_PARITY_EN.
- Defined:
  - Each RAM word carries one extra even-parity bit, computed from ld_data on write.
  - Adds input ld_par_inj (1 bit): when high on a write, the stored parity bit is inverted.
  - Adds output par_err (1 bit, reset 0): pulses together with data_valid when a served word's parity mismatches. data is still driven with the stored word.
  - NOP_WORD returns never assert par_err.
- Not defined: no parity storage; ld_par_inj and par_err ports are absent. All other behaviour is identical.

Test Plan:
1. Reset, then fetch_req=1 with im_cs=1, address=1 -> next cycle data_valid=1, data=0x00, loaded=0.
2. ld_start, stream 0x24,0x84,0x60,0xB0 with ld_valid continuous -> ld_ready high for 4 cycles, ld_done pulse on the 5th cycle, loaded=1, busy=0 afterwards. Fetch addresses 0..3 back-to-back -> 0x24,0x84,0x60,0xB0 on consecutive cycles, each 1 cycle after its request.
3. Load with ld_valid gaps (valid pattern 1,0,0,1,1,0,1) -> exactly 4 writes, ld_done after the 4th; readback matches.
4. loaded=1, im_cs=0, fetch address 2 -> data=0x00, data_valid=1. Fetch during a reload -> 0x00 and loaded=0 until the new ld_done.
5. Assert rst_n=0 after 2 of 4 load words -> all outputs at reset values immediately. A fetch then returns 0x00. A fresh full load succeeds.
6. (IM_PARITY_EN) Load with ld_par_inj=1 on word 3 -> fetch of address 3 gives par_err=1 with data=0xB0. Fetches of addresses 0..2 give par_err=0.
